// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and mret, flushes/drains the pipe,
// writes mepc/mcause/mtval through one CSR port, updates mstatus and redirects fetch.
module trap_sequencer #(
   parameter int unsigned XLEN   = 32,
   parameter logic [5:0]  NO_EXC = 6'h1F
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [5:0]      exc_code,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic [2:0]      irq_pending,
   input  logic            mstatus_mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc_in,
   input  logic            mret_req,
   input  logic            pipe_empty,
   output logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            csr_we,
   output logic [1:0]      csr_sel,
   output logic [XLEN-1:0] csr_wdata,
   output logic            mstatus_trap,
   output logic            mstatus_mret
);

   typedef enum logic [3:0] {
      st_idle, st_flush, st_drain, st_w_epc, st_w_cause, st_w_tval, st_redirect,
      st_m_flush, st_m_drain, st_m_ret
   } state_t;

   state_t            state, state_d;
   logic [5:0]        code_q;
   logic [XLEN-1:0]   pc_q, tval_q, redirect_q, base, trap_target;
   logic              is_irq_q;
   logic              take_exc, take_irq, take_mret;
   logic [5:0]        irq_code;

   assign take_exc  = (exc_code != NO_EXC);
   assign take_irq  = !take_exc && mstatus_mie && (irq_pending != 3'b000);
   assign take_mret = !take_exc && !take_irq && mret_req;
   assign irq_code  = irq_pending[2] ? 6'd11 : (irq_pending[0] ? 6'd3 : 6'd7);

   // Vectored mode only offsets interrupts; modes 2 and 3 fall back to direct.
   assign base        = {mtvec[XLEN-1:2], 2'b00};
   assign trap_target = (mtvec[1:0] == 2'b01 && is_irq_q) ?
                        base + {{(XLEN-8){1'b0}}, code_q, 2'b00} : base;

   always_comb begin
      state_d = state;
      unique case (state)
         st_idle: begin
            if (take_exc || take_irq) state_d = st_flush;
            else if (take_mret)       state_d = st_m_flush;
         end
         st_flush:    state_d = st_drain;
         st_drain:    if (pipe_empty) state_d = st_w_epc;
         st_w_epc:    state_d = st_w_cause;
         st_w_cause:  state_d = st_w_tval;
         st_w_tval:   state_d = st_redirect;
         st_redirect: state_d = st_idle;
         st_m_flush:  state_d = st_m_drain;
         st_m_drain:  if (pipe_empty) state_d = st_m_ret;
         st_m_ret:    state_d = st_idle;
         default:     state_d = st_idle;
      endcase
   end

   // Outputs are registered from the next state so each one lines up with its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= st_idle;
         code_q         <= '0;
         pc_q           <= '0;
         tval_q         <= '0;
         is_irq_q       <= 1'b0;
         flush          <= 1'b0;
         busy           <= 1'b0;
         csr_we         <= 1'b0;
         csr_sel        <= 2'd0;
         csr_wdata      <= '0;
         redirect_valid <= 1'b0;
         redirect_q     <= '0;
         mstatus_trap   <= 1'b0;
         mstatus_mret   <= 1'b0;
      end else begin
         state <= state_d;
         if (state == st_idle) begin
            if (take_exc) begin
               code_q   <= exc_code;
               pc_q     <= exc_pc;
               tval_q   <= exc_tval;
               is_irq_q <= 1'b0;
            end else if (take_irq) begin
               code_q   <= irq_code;
               pc_q     <= exc_pc;
               tval_q   <= '0;
               is_irq_q <= 1'b1;
            end
         end
         flush          <= (state_d == st_flush) || (state_d == st_m_flush);
         busy           <= (state_d != st_idle);
         csr_we         <= (state_d == st_w_epc) || (state_d == st_w_cause) ||
                           (state_d == st_w_tval);
         redirect_valid <= (state_d == st_redirect) || (state_d == st_m_ret);
         redirect_q     <= (state_d == st_redirect) ? trap_target : '0;
         mstatus_trap   <= (state_d == st_redirect);
         mstatus_mret   <= (state_d == st_m_ret);
         case (state_d)
            st_w_epc: begin
               csr_sel   <= 2'd0;
               csr_wdata <= pc_q;
            end
            st_w_cause: begin
               csr_sel   <= 2'd1;
               csr_wdata <= {is_irq_q, {(XLEN-7){1'b0}}, code_q};
            end
            st_w_tval: begin
               csr_sel   <= 2'd2;
               csr_wdata <= tval_q;
            end
            default: begin
               csr_sel   <= 2'd0;
               csr_wdata <= '0;
            end
         endcase
      end
   end

   assign stall = busy;
   // mret target follows mepc_in live during the return cycle.
   assign redirect_pc = (state == st_m_ret) ? mepc_in : redirect_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: driver pushes expected events from a reference model,
// a negedge monitor pops and compares whenever the DUT shows an output event.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  exc_code;
   logic [31:0] exc_pc, exc_tval, mtvec, mepc_in;
   logic [2:0]  irq_pending;
   logic        mstatus_mie, mret_req, pipe_empty;
   logic        flush, stall, busy, redirect_valid, csr_we, mstatus_trap, mstatus_mret;
   logic [31:0] redirect_pc, csr_wdata;
   logic [1:0]  csr_sel;

   trap_sequencer #(.XLEN(32), .NO_EXC(6'h1F)) dut (
      .clk(clk), .rst_n(rst_n), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .irq_pending(irq_pending), .mstatus_mie(mstatus_mie), .mtvec(mtvec), .mepc_in(mepc_in),
      .mret_req(mret_req), .pipe_empty(pipe_empty), .flush(flush), .stall(stall), .busy(busy),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .csr_we(csr_we),
      .csr_sel(csr_sel), .csr_wdata(csr_wdata), .mstatus_trap(mstatus_trap),
      .mstatus_mret(mstatus_mret)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        fl;
      logic        we;
      logic [1:0]  sel;
      logic [31:0] wd;
      logic        rv;
      logic [31:0] rpc;
      logic        mt;
      logic        mr;
   } ev_t;

   ev_t  expq[$];
   ev_t  mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   bs = 1, be = 0;
   logic exp_b;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic ev_t mk(input int c, input logic fl, input logic we, input logic [1:0] sel,
                              input logic [31:0] wd, input logic rv, input logic [31:0] rpc,
                              input logic mt, input logic mr);
      ev_t e;
      e.cyc = c; e.fl = fl; e.we = we; e.sel = sel; e.wd = wd;
      e.rv = rv; e.rpc = rpc; e.mt = mt; e.mr = mr;
      return e;
   endfunction

   // Monitor: busy window every cycle, event comparison whenever anything fires.
   always @(negedge clk) begin
      exp_b = (cyc >= bs) && (cyc <= be);
      check("busy", busy, exp_b);
      check("stall", stall, exp_b);
      if (flush || csr_we || redirect_valid || mstatus_trap || mstatus_mret) begin
         if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event cyc=%0d: got fl=%0b we=%0b rv=%0b mt=%0b mr=%0b expected none",
                     cyc, flush, csr_we, redirect_valid, mstatus_trap, mstatus_mret);
         end else begin
            mon_e = expq.pop_front();
            check("event_cycle", cyc, mon_e.cyc);
            check("flush", flush, mon_e.fl);
            check("csr_we", csr_we, mon_e.we);
            if (mon_e.we) begin
               check("csr_sel", csr_sel, mon_e.sel);
               check("csr_wdata", csr_wdata, mon_e.wd);
            end
            check("redirect_valid", redirect_valid, mon_e.rv);
            if (mon_e.rv) check("redirect_pc", redirect_pc, mon_e.rpc);
            check("mstatus_trap", mstatus_trap, mon_e.mt);
            check("mstatus_mret", mstatus_mret, mon_e.mr);
         end
      end
   end

   task automatic drive_idle();
      exc_code    = 6'h1F;
      irq_pending = 3'b000;
      mret_req    = 1'b0;
      mstatus_mie = 1'b0;
      exc_pc      = 32'h0;
      exc_tval    = 32'h0;
   endtask

   // Presents one event at the current cycle, predicts the response, then plays junk inputs
   // and the drain pattern until the sequence ends. Must be entered just after a posedge.
   task automatic run_txn(input logic [5:0] ec, input logic [2:0] irq, input logic mie,
                          input logic mr, input logic [31:0] pc, input logic [31:0] tval,
                          input logic [31:0] tvec, input logic [31:0] mepc, input int d);
      int          n, last;
      int          code;
      logic        is_irq;
      logic [31:0] target, cause;
      n = cyc;
      exc_code = ec; irq_pending = irq; mstatus_mie = mie; mret_req = mr;
      exc_pc = pc; exc_tval = tval; mtvec = tvec; mepc_in = mepc; pipe_empty = 1'b1;
      last = n;
      if (ec != 6'h1F || (mie && irq != 3'b000)) begin
         is_irq = (ec == 6'h1F);
         if (!is_irq) code = int'(ec);
         else if (irq[2]) code = 11;
         else if (irq[0]) code = 3;
         else code = 7;
         if (is_irq) tval = 32'h0;
         cause  = (is_irq ? 32'h8000_0000 : 32'h0) + 32'(code);
         target = tvec & ~32'h3;
         if (tvec[1:0] == 2'b01 && is_irq) target = target + 32'(code * 4);
         last = n + 6 + d;
         expq.push_back(mk(n + 1, 1, 0, 0, 0, 0, 0, 0, 0));
         expq.push_back(mk(n + 3 + d, 0, 1, 2'd0, pc, 0, 0, 0, 0));
         expq.push_back(mk(n + 4 + d, 0, 1, 2'd1, cause, 0, 0, 0, 0));
         expq.push_back(mk(n + 5 + d, 0, 1, 2'd2, tval, 0, 0, 0, 0));
         expq.push_back(mk(n + 6 + d, 0, 0, 0, 0, 1, target, 1, 0));
      end else if (mr) begin
         last = n + 3 + d;
         expq.push_back(mk(n + 1, 1, 0, 0, 0, 0, 0, 0, 0));
         expq.push_back(mk(n + 3 + d, 0, 0, 0, 0, 1, mepc, 0, 1));
      end
      bs = n + 1;
      be = last;
      @(posedge clk); #1;
      while (cyc <= last) begin
         exc_code    = 6'($urandom);
         irq_pending = 3'($urandom);
         mstatus_mie = 1'($urandom);
         mret_req    = 1'($urandom);
         exc_pc      = $urandom;
         exc_tval    = $urandom;
         pipe_empty  = !((cyc >= n + 2) && (cyc <= n + 1 + d));
         @(posedge clk); #1;
      end
      drive_idle();
      pipe_empty = 1'b1;
   endtask

   task automatic reset_in_drain();
      int n;
      n = cyc;
      exc_code = 6'd5; exc_pc = 32'h400; exc_tval = 32'h1234; mtvec = 32'h8000_0000;
      pipe_empty = 1'b1;
      expq.push_back(mk(n + 1, 1, 0, 0, 0, 0, 0, 0, 0));
      bs = n + 1;
      be = n + 2;
      @(posedge clk); #1;
      drive_idle();
      pipe_empty = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy_before_reset", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("outputs_in_reset",
               {flush, stall, busy, redirect_valid, csr_we, mstatus_trap, mstatus_mret,
                csr_sel, redirect_pc, csr_wdata}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pipe_empty = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      drive_idle();
      mtvec = 32'h0; mepc_in = 32'h0; pipe_empty = 1'b1;
      #3 check("reset_outputs",
               {flush, stall, busy, redirect_valid, csr_we, mstatus_trap, mstatus_mret,
                csr_sel, redirect_pc, csr_wdata}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_txn(6'd2, 3'b000, 0, 0, 32'h100, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0, 0);
      run_txn(6'h1F, 3'b010, 1, 0, 32'h240, 32'h77, 32'h8000_0001, 32'h0, 0);
      run_txn(6'h1F, 3'b111, 0, 0, 32'h300, 32'h0, 32'h8000_0001, 32'h0, 0);
      run_txn(6'h1F, 3'b111, 1, 0, 32'h300, 32'h0, 32'h8000_0000, 32'h0, 0);
      run_txn(6'd8, 3'b001, 1, 1, 32'h500, 32'h0, 32'h8000_0001, 32'h900, 0);
      run_txn(6'd4, 3'b000, 0, 0, 32'h600, 32'h55, 32'h8000_0000, 32'h0, 5);
      run_txn(6'h1F, 3'b000, 0, 1, 32'h0, 32'h0, 32'h8000_0000, 32'h204, 0);
      run_txn(6'h1F, 3'b001, 1, 0, 32'h700, 32'h0, 32'hFFFF_FFFD, 32'h0, 2);
      reset_in_drain();

      for (int i = 0; i < 150; i++) begin
         run_txn(($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h1F, 3'($urandom),
                 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 4)));
      end

      repeat (3) @(posedge clk);
      #1 check("queue_empty", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Machine-mode trap controller that sequences trap entry and mret for the RISC-V core.
- Consumes the prioritized 6-bit exception cause from the exception decoder, plus masked interrupt-pending lines and mret requests.
- Flushes and drains the pipeline, writes mepc/mcause/mtval over a single CSR write port, updates mstatus, and redirects fetch.
- Sits between the decode/exception logic, the CSR file and the PC-select mux.

Parameters:
XLEN, 32, datapath and CSR width.
NO_EXC, 6'h1F, cause value meaning "no exception present".

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
exc_code  in  6  prioritized exception cause; NO_EXC = none.
exc_pc  in  XLEN  PC of the oldest in-flight instruction (faulting instruction, or resume PC for interrupts).
exc_tval  in  XLEN  trap value associated with the exception.
irq_pending  in  3  pending interrupts, already ANDed with mie: [0]=MSI, [1]=MTI, [2]=MEI.
mstatus_mie  in  1  global machine interrupt enable.
mtvec  in  XLEN  trap vector CSR.
mepc_in  in  XLEN  current mepc, used as the mret target.
mret_req  in  1  mret instruction reached commit.
pipe_empty  in  1  pipeline has no in-flight instructions.
flush  out  1  kill all in-flight instructions.
stall  out  1  hold fetch/issue.
busy  out  1  FSM not in IDLE.
redirect_valid  out  1  load redirect_pc into the PC.
redirect_pc  out  XLEN  redirect target.
csr_we  out  1  CSR write strobe.
csr_sel  out  2  write target: 0=mepc, 1=mcause, 2=mtval.
csr_wdata  out  XLEN  CSR write data.
mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0, MPP<=M.
mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1.

Behaviour:
- Reset (async, rst_n=0):
  - State forced to IDLE; all outputs 0; latched code/pc/tval/irq flag cleared.
  - Reset asserted mid-sequence aborts the sequence with no further CSR writes or redirect.
- States: IDLE, FLUSH, DRAIN, W_EPC, W_CAUSE, W_TVAL, REDIRECT, M_FLUSH, M_DRAIN, M_RET. All outputs are Moore (decoded from state and latched registers only).
- IDLE acceptance priority, evaluated each cycle:
  1. exc_code != NO_EXC: latch code, exc_pc, exc_tval; is_irq=0; go to FLUSH.
  2. else if mstatus_mie and irq_pending != 0: select MEI(11) > MSI(3) > MTI(7); latch that code and exc_pc; tval=0; is_irq=1; go to FLUSH.
  3. else if mret_req: go to M_FLUSH.
- Inputs are ignored in every state other than IDLE; events arriving mid-sequence are lost, and upstream re-presents them after the flush.
- FLUSH: flush=1 for exactly one cycle, then DRAIN.
- DRAIN: waits with no timeout while pipe_empty=0; when pipe_empty=1, go to W_EPC.
- W_EPC: csr_we=1, csr_sel=0, csr_wdata=latched pc.
- W_CAUSE: csr_we=1, csr_sel=1, csr_wdata = {is_irq, (XLEN-7) zeros, code}.
- W_TVAL: csr_we=1, csr_sel=2, csr_wdata = latched tval (0 for interrupts).
- REDIRECT: redirect_valid=1 and mstatus_trap=1 for one cycle, then IDLE.
  - base = {mtvec[XLEN-1:2], 2'b00}.
  - If mtvec[1:0]==1 and is_irq: redirect_pc = base + (code<<2), modulo 2^XLEN.
  - Otherwise redirect_pc = base. mtvec modes 2 and 3 are treated as direct.
- M_FLUSH: flush=1 for one cycle. M_DRAIN: wait for pipe_empty=1. M_RET: redirect_valid=1, redirect_pc = mepc_in sampled in that cycle, mstatus_mret=1; then IDLE.
- stall=1 and busy=1 in every non-IDLE state. csr_we=0 outside the W_* states.
- Latency with pipe_empty=1: accept at cycle N, flush at N+1, CSR writes at N+3..N+5, redirect at N+6. mret: flush at N+1, redirect at N+3.

Test Plan:
- Illegal-instruction trap: exc_code=2, exc_pc=0x100, exc_tval=0xDEADBEEF, mtvec=0x80000000, pipe_empty=1 -> flush at N+1; writes mepc=0x100, mcause=0x2, mtval=0xDEADBEEF; redirect to 0x80000000 with mstatus_trap at N+6.
- Vectored timer interrupt: mtvec=0x80000001, irq_pending=3'b010, mstatus_mie=1, exc_pc=0x240 -> mcause=0x80000007, mtval=0, mepc=0x240, redirect_pc=0x8000001C.
- Masking and priority:
  - irq_pending=3'b111 with mstatus_mie=0 -> no action, busy stays 0.
  - Same pending lines with mstatus_mie=1 -> mcause=0x8000000B (MEI wins).
- Simultaneous exc_code=8, irq_pending=3'b001 and mret_req=1 -> ecall trap taken with mcause=0x8; mret and interrupt ignored.
- pipe_empty held 0 for 5 cycles after flush -> stall held, no csr_we during the wait; writes and redirect shift out by exactly 5 cycles. Then mret with mepc_in=0x204 -> flush, redirect_pc=0x204, mstatus_mret pulse.
- rst_n pulsed low while in DRAIN -> all outputs 0 immediately; after release, FSM in IDLE with no CSR writes or redirect emitted.
